request_unit: RTL and testbench

REQUEST_UNIT -- requirements
Module: request_unit

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/control_unit_if.sv | 12 +
 rtl/sat_counter.sv | 39 +++
 rtl/request_unit.sv | 101 ++++++++++
 tb/tb_request_unit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and widths for the request unit and its helpers.
package cpu_types_pkg;

   localparam int unsigned STALL_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      HALTED = 2'd2
   } ru_state_t;

endpackage

// File: rtl/control_unit_if.sv
// Decoded per-instruction requests from the control unit to the request unit.
interface control_unit_if;

   logic memRead;
   logic memWrite;
   logic datomic;
   logic halt;

   modport cu (output memRead, memWrite, datomic, halt);
   modport ru (input  memRead, memWrite, datomic, halt);

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones maximum.
module sat_counter
   import cpu_types_pkg::*;
#(
   parameter int unsigned W = STALL_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Clear wins over increment so a new request always starts from zero.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != CNT_MAX)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/request_unit.sv
// Sequences instruction fetch, one outstanding data access and halt for a
// single-issue pipeline; pcEn pulses once per completed instruction.
module request_unit
   import cpu_types_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   ihit,
   input  logic                   dhit,
   control_unit_if.ru             cu_if,
   output logic                   imemREN,
   output logic                   dmemREN,
   output logic                   dmemWEN,
   output logic                   dmematomic,
   output logic                   pcEn,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   ru_state_t state_q;
   logic      dmem_ren_q;
   logic      dmem_wen_q;
   logic      dmem_atomic_q;
   logic      halted_q;

   logic idle_c;
   logic data_c;
   logic any_req_c;
   logic start_c;
   logic done_c;
   logic stall_inc_c;

   // Reset masks every combinational strobe so nothing leaks while RST is high.
   always_comb begin
      idle_c      = !RST && (state_q == IDLE);
      data_c      = !RST && (state_q == DATA);
      any_req_c   = cu_if.memRead || cu_if.memWrite;
      start_c     = idle_c && ihit && !cu_if.halt && any_req_c;
      done_c      = data_c && dhit;
      stall_inc_c = data_c && !dhit;
   end

   assign imemREN    = idle_c;
   assign pcEn       = (idle_c && ihit && !cu_if.halt && !any_req_c) || done_c;
   assign dmemREN    = dmem_ren_q;
   assign dmemWEN    = dmem_wen_q;
   assign dmematomic = dmem_atomic_q;
   assign halted     = halted_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= IDLE;
         dmem_ren_q    <= 1'b0;
         dmem_wen_q    <= 1'b0;
         dmem_atomic_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ihit) begin
                  if (cu_if.halt) begin
                     state_q  <= HALTED;
                     halted_q <= 1'b1;
                  end else if (any_req_c) begin
                     // A store outranks a load decoded in the same instruction.
                     state_q       <= DATA;
                     dmem_wen_q    <= cu_if.memWrite;
                     dmem_ren_q    <= !cu_if.memWrite;
                     dmem_atomic_q <= cu_if.datomic;
                  end
               end
            end
            DATA: begin
               if (dhit) begin
                  state_q       <= IDLE;
                  dmem_ren_q    <= 1'b0;
                  dmem_wen_q    <= 1'b0;
                  dmem_atomic_q <= 1'b0;
               end
            end
            HALTED: begin
               state_q <= HALTED;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk     (CLK),
      .rst     (RST),
      .clr_i   (start_c),
      .inc_i   (stall_inc_c),
      .count_o (stall_cnt)
   );

endmodule

// File: tb/tb_request_unit.sv
// Directed scenario bench for request_unit; inputs change 1 time unit after
// each rising edge and outputs are sampled 1 unit later.
module tb_request_unit;
   import cpu_types_pkg::*;

   logic                   CLK;
   logic                   RST;
   logic                   ihit;
   logic                   dhit;
   logic                   imemREN;
   logic                   dmemREN;
   logic                   dmemWEN;
   logic                   dmematomic;
   logic                   pcEn;
   logic                   halted;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic [5:0]             outs;

   int tests_run;
   int tests_failed;

   control_unit_if cu_if ();

   request_unit dut (
      .CLK        (CLK),
      .RST        (RST),
      .ihit       (ihit),
      .dhit       (dhit),
      .cu_if      (cu_if),
      .imemREN    (imemREN),
      .dmemREN    (dmemREN),
      .dmemWEN    (dmemWEN),
      .dmematomic (dmematomic),
      .pcEn       (pcEn),
      .halted     (halted),
      .stall_cnt  (stall_cnt)
   );

   // Packed view: {imemREN, dmemREN, dmemWEN, dmematomic, pcEn, halted}
   assign outs = {imemREN, dmemREN, dmemWEN, dmematomic, pcEn, halted};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic i, input logic d, input logic rd,
                        input logic wr, input logic at, input logic h);
      ihit           = i;
      dhit           = d;
      cu_if.memRead  = rd;
      cu_if.memWrite = wr;
      cu_if.datomic  = at;
      cu_if.halt     = h;
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      cyc();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b000000) begin
         tests_failed++;
         $display("FAIL reset_outs: got %b, expected %b", outs, 6'b000000);
      end
      tests_run++;
      if (stall_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_stall: got %0d, expected %0d", stall_cnt, 0);
      end
      cyc();
      RST = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b100000) begin
         tests_failed++;
         $display("FAIL post_reset_idle: got %b, expected %b", outs, 6'b100000);
      end
   endtask

   task automatic test_idle_fetch();
      cyc();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b100010) begin
         tests_failed++;
         $display("FAIL fetch_pcen: got %b, expected %b", outs, 6'b100010);
      end
      cyc();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b100000) begin
         tests_failed++;
         $display("FAIL idle_dhit_ignored: got %b, expected %b", outs, 6'b100000);
      end
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b100000) begin
         tests_failed++;
         $display("FAIL idle_stays: got %b, expected %b", outs, 6'b100000);
      end
   endtask

   task automatic test_load();
      int ren_cycles;
      int pc_pulses;
      logic [5:0] exp;
      ren_cycles = 0;
      pc_pulses  = 0;
      cyc();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b100000) begin
         tests_failed++;
         $display("FAIL load_issue: got %b, expected %b", outs, 6'b100000);
      end
      for (int k = 1; k <= 4; k++) begin
         cyc();
         drive(1'b1, (k == 4), 1'b0, 1'b0, 1'b0, 1'b0);
         if (dmemREN === 1'b1) ren_cycles++;
         if (pcEn === 1'b1) pc_pulses++;
         exp = (k == 4) ? 6'b010010 : 6'b010000;
         tests_run++;
         if (outs !== exp) begin
            tests_failed++;
            $display("FAIL load_data_c%0d: got %b, expected %b", k, outs, exp);
         end
         tests_run++;
         if (stall_cnt !== 8'(k - 1)) begin
            tests_failed++;
            $display("FAIL load_stall_c%0d: got %0d, expected %0d", k, stall_cnt, k - 1);
         end
      end
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (dmemREN === 1'b1) ren_cycles++;
      tests_run++;
      if (outs !== 6'b100000 || stall_cnt !== 8'd3) begin
         tests_failed++;
         $display("FAIL load_done: got %b/%0d, expected %b/%0d", outs, stall_cnt, 6'b100000, 3);
      end
      tests_run++;
      if (ren_cycles != 4 || pc_pulses != 1) begin
         tests_failed++;
         $display("FAIL load_counts: got ren=%0d pc=%0d, expected ren=4 pc=1", ren_cycles, pc_pulses);
      end
   endtask

   task automatic test_atomic_write();
      logic [5:0] exp;
      cyc();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tests_run++;
      if (outs !== 6'b100000) begin
         tests_failed++;
         $display("FAIL atomic_issue: got %b, expected %b", outs, 6'b100000);
      end
      for (int k = 1; k <= 3; k++) begin
         cyc();
         drive(1'b0, (k == 3), 1'b1, 1'b1, 1'b0, 1'b0);
         exp = (k == 3) ? 6'b001110 : 6'b001100;
         tests_run++;
         if (outs !== exp || stall_cnt !== 8'(k - 1)) begin
            tests_failed++;
            $display("FAIL atomic_data_c%0d: got %b/%0d, expected %b/%0d", k, outs, stall_cnt, exp, k - 1);
         end
      end
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b100000) begin
         tests_failed++;
         $display("FAIL atomic_clear: got %b, expected %b", outs, 6'b100000);
      end
   endtask

   task automatic test_saturate();
      int bad_imem;
      int bad_cnt;
      logic [7:0] e8;
      bad_imem = 0;
      bad_cnt  = 0;
      cyc();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 300; k++) begin
         cyc();
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         e8 = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
         if (imemREN !== 1'b0) bad_imem++;
         if (stall_cnt !== e8) bad_cnt++;
      end
      tests_run++;
      if (bad_imem != 0) begin
         tests_failed++;
         $display("FAIL sat_imem_low: got %0d bad cycles, expected 0", bad_imem);
      end
      tests_run++;
      if (bad_cnt != 0 || stall_cnt !== 8'd255) begin
         tests_failed++;
         $display("FAIL sat_count: got %0d bad cycles, final %0d, expected 0 and 255", bad_cnt, stall_cnt);
      end
      cyc();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b010010 || stall_cnt !== 8'd255) begin
         tests_failed++;
         $display("FAIL sat_dhit: got %b/%0d, expected %b/%0d", outs, stall_cnt, 6'b010010, 255);
      end
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b100000 || stall_cnt !== 8'd255) begin
         tests_failed++;
         $display("FAIL sat_idle_hold: got %b/%0d, expected %b/%0d", outs, stall_cnt, 6'b100000, 255);
      end
   endtask

   task automatic test_halt();
      int wen_seen;
      int bad_halt;
      wen_seen = 0;
      bad_halt = 0;
      cyc();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      if (dmemWEN !== 1'b0) wen_seen++;
      tests_run++;
      if (outs !== 6'b100000) begin
         tests_failed++;
         $display("FAIL halt_issue: got %b, expected %b", outs, 6'b100000);
      end
      for (int k = 1; k <= 6; k++) begin
         cyc();
         drive(1'b1, ((k % 2) == 1), 1'b1, 1'b1, 1'b0, ((k % 3) == 0));
         if (dmemWEN !== 1'b0) wen_seen++;
         if (outs !== 6'b000001) bad_halt++;
      end
      tests_run++;
      if (wen_seen != 0) begin
         tests_failed++;
         $display("FAIL halt_no_wen: got %0d cycles with dmemWEN, expected 0", wen_seen);
      end
      tests_run++;
      if (bad_halt != 0 || halted !== 1'b1) begin
         tests_failed++;
         $display("FAIL halt_sticky: got %0d bad cycles halted=%b, expected 0 and 1", bad_halt, halted);
      end
      tests_run++;
      if (stall_cnt !== 8'd255) begin
         tests_failed++;
         $display("FAIL halt_stall_hold: got %0d, expected %0d", stall_cnt, 255);
      end
   endtask

   task automatic test_reset_mid_data();
      cyc();
      RST = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b000001) begin
         tests_failed++;
         $display("FAIL rst_in_halt: got %b, expected %b", outs, 6'b000001);
      end
      cyc();
      RST = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tests_run++;
      if (outs !== 6'b100000 || stall_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL rst_leave_halt: got %b/%0d, expected %b/%0d", outs, stall_cnt, 6'b100000, 0);
      end
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b001100) begin
         tests_failed++;
         $display("FAIL rst_pre_data: got %b, expected %b", outs, 6'b001100);
      end
      cyc();
      RST = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b001100 || stall_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL rst_during_data: got %b/%0d, expected %b/%0d", outs, stall_cnt, 6'b001100, 1);
      end
      cyc();
      RST = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (outs !== 6'b100000 || stall_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL rst_mid_data: got %b/%0d, expected %b/%0d", outs, stall_cnt, 6'b100000, 0);
      end
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      RST            = 1'b1;
      ihit           = 1'b0;
      dhit           = 1'b0;
      cu_if.memRead  = 1'b0;
      cu_if.memWrite = 1'b0;
      cu_if.datomic  = 1'b0;
      cu_if.halt     = 1'b0;
      test_reset();
      test_idle_fetch();
      test_load();
      test_atomic_write();
      test_saturate();
      test_halt();
      test_reset_mid_data();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
